// File: rtl/bcd_pulse_tx.sv
// Pulse-count transmitter: sends a 3-digit BCD count as fixed-width pulses on one wire.
// Optional `abort` input is enabled by defining BCD_PULSE_TX_ABORT_EN.
module bcd_pulse_tx #(
  parameter int unsigned HIGH_CYCLES = 50000,
  parameter int unsigned LOW_CYCLES  = 50000,
  parameter int unsigned TW          = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] bcd_in,
`ifdef BCD_PULSE_TX_ABORT_EN
  input  logic        abort,
`endif
  output logic        data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] remaining
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [TW-1:0] HighLast = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LowLast  = TW'(LOW_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [11:0]   rem_q, rem_d;

  function automatic logic bcd_valid(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Digit-wise borrow; caller guarantees v != 000.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!bcd_valid(bcd_in)) begin
            err_d = 1'b1;
          end else if (bcd_in == 12'h000) begin
            done_d = 1'b1;
          end else begin
            rem_d   = bcd_in;
            data_d  = 1'b1;
            busy_d  = 1'b1;
            timer_d = '0;
            state_d = StHigh;
          end
        end
      end
      StHigh: begin
        if (timer_q == HighLast) begin
          data_d  = 1'b0;
          rem_d   = bcd_dec(rem_q);
          timer_d = '0;
          state_d = StLow;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StLow: begin
        if (timer_q == LowLast) begin
          timer_d = '0;
          if (rem_q != 12'h000) begin
            data_d  = 1'b1;
            state_d = StHigh;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef BCD_PULSE_TX_ABORT_EN
    // Abort freezes the display on the count that was still unsent.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      timer_d = '0;
      data_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rem_d   = rem_q;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= 12'h000;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
    end
  end

  assign data      = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_bcd_pulse_tx.sv
// Scoreboard bench for bcd_pulse_tx with HIGH_CYCLES=2, LOW_CYCLES=3.
module tb_bcd_pulse_tx;
  localparam int H = 2;
  localparam int L = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic        abort = 1'b0;
  logic        data, busy, done, err;
  logic [11:0] remaining;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int rise_cyc = 0;
  int done_cnt = 0;
  logic prev_data = 1'b0;
  logic [11:0] rem_q[$];
  int          done_q[$];

  bcd_pulse_tx #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .TW(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .bcd_in    (bcd_in),
`ifdef BCD_PULSE_TX_ABORT_EN
    .abort     (abort),
`endif
    .data      (data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Expected remaining after each falling edge, then the pulse count for done.
  task automatic expect_train(input logic [11:0] b);
    int n;
    n = from_bcd(b);
    for (int k = n - 1; k >= 0; k--) rem_q.push_back(to_bcd(k));
    done_q.push_back(n);
  endtask

  // Monitor: samples on the falling clock edge.
  initial begin
    logic [11:0] er;
    int en;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        prev_data = 1'b0;
        pulse_cnt = 0;
      end else begin
        if (data && !prev_data) begin
          if (pulse_cnt == 0) rise_cyc = cyc;
          pulse_cnt++;
        end
        if (!data && prev_data && busy) begin
          checks++;
          if (rem_q.size() == 0) begin
            errors++;
            $display("FAIL rem_fall: unexpected falling edge, remaining=%h", remaining);
          end else begin
            er = rem_q.pop_front();
            if (remaining !== er) begin
              errors++;
              $display("FAIL rem_fall: remaining=%h expected %h", remaining, er);
            end
          end
        end
        if (done) begin
          done_cnt++;
          checks++;
          if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexp: done=1 expected 0");
          end else begin
            en = done_q.pop_front();
            if (pulse_cnt !== en) begin
              errors++;
              $display("FAIL pulse_count: got %0d expected %0d", pulse_cnt, en);
            end
            if (en > 0) begin
              checks++;
              if (cyc - rise_cyc !== en * (H + L)) begin
                errors++;
                $display("FAIL done_timing: got %0d expected %0d", cyc - rise_cyc, en * (H + L));
              end
            end
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: busy=%b expected 0", busy);
          end
          pulse_cnt = 0;
        end
        prev_data = data;
      end
    end
  end

  task automatic drive_start(input logic [11:0] b);
    @(negedge clock);
    start = 1'b1;
    bcd_in = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c0;
    int n;
    c0 = done_cnt;
    n = 0;
    while (done_cnt == c0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (done_cnt == c0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({data, busy, done, err, remaining} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got %b%b%b%b %h expected all zero", data, busy, done, err,
               remaining);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_three;
    expect_train(12'h003);
    drive_start(12'h003);
    checks++;
    if (data !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_rise: data=%b busy=%b expected 1 1", data, busy);
    end
    wait_done(100, "three");
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b expected 0", done);
    end
  endtask

  task automatic test_hundred;
    expect_train(12'h100);
    drive_start(12'h100);
    wait_done(700, "hundred");
    checks++;
    if (rem_q.size() != 0) begin
      errors++;
      $display("FAIL hundred_queue: %0d entries left expected 0", rem_q.size());
    end
  endtask

  task automatic test_err;
    drive_start(12'h0A5);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || data !== 1'b0 || remaining !== 12'h000) begin
      errors++;
      $display("FAIL err_strobe: err=%b busy=%b data=%b rem=%h expected 1 0 0 000", err, busy,
               data, remaining);
    end
    @(negedge clock);
    checks++;
    if (err !== 1'b0 || data !== 1'b0) begin
      errors++;
      $display("FAIL err_width: err=%b data=%b expected 0 0", err, data);
    end
  endtask

  task automatic test_zero;
    done_q.push_back(0);
    drive_start(12'h000);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b data=%b expected 1 0 0", done, busy, data);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || data !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: done=%b busy=%b data=%b expected 0 0 0", done, busy, data);
    end
  endtask

  task automatic test_start_while_busy;
    expect_train(12'h005);
    drive_start(12'h005);
    repeat (7) @(negedge clock);
    start = 1'b1;
    bcd_in = 12'h009;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: err=%b busy=%b expected 0 1", err, busy);
    end
    wait_done(200, "busy_start");
  endtask

  task automatic test_held_start;
    expect_train(12'h001);
    expect_train(12'h001);
    @(negedge clock);
    start = 1'b1;
    bcd_in = 12'h001;
    wait_done(50, "held1");
    @(negedge clock);
    checks++;
    if (data !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL held_restart: data=%b busy=%b expected 1 1", data, busy);
    end
    start = 1'b0;
    wait_done(50, "held2");
  endtask

  task automatic test_reset_mid;
    expect_train(12'h003);
    drive_start(12'h003);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({data, busy, done, err, remaining} !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got %b%b%b%b %h expected all zero", data, busy, done, err,
               remaining);
    end
    repeat (2) @(negedge clock);
    rem_q.delete();
    done_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
  endtask

`ifdef BCD_PULSE_TX_ABORT_EN
  task automatic test_abort;
    int n;
    rem_q.push_back(12'h006);
    rem_q.push_back(12'h005);
    drive_start(12'h007);
    n = 0;
    while (pulse_cnt < 3 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checks++;
    if (data !== 1'b0 || busy !== 1'b0 || remaining !== 12'h005 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: data=%b busy=%b rem=%h done=%b expected 0 0 005 0", data, busy,
               remaining, done);
    end
    pulse_cnt = 0;
    repeat (20) @(negedge clock);
    checks++;
    if (rem_q.size() != 0 || data !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: queue=%0d data=%b expected 0 0", rem_q.size(), data);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_three();
    test_hundred();
    test_err();
    test_zero();
    test_start_while_busy();
    test_held_start();
    test_reset_mid();
`ifdef BCD_PULSE_TX_ABORT_EN
    test_abort();
`endif
    repeat (5) @(negedge clock);
    checks++;
    if (done_q.size() != 0 || rem_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: done_q=%0d rem_q=%0d expected 0 0", done_q.size(),
               rem_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
